score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 106 ++++++++++
 tb/tb_score_keeper.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Level / best-score keeper for the colour-memory game.
// BCD level and max digits, IDLE/PLAY/OVER state and background code.
module score_keeper #(
  parameter int       MAX_LEVEL = 99,
  parameter bit [2:0] BG_IDLE   = 3'b001,
  parameter bit [2:0] BG_PLAY   = 3'b000,
  parameter bit [2:0] BG_OVER   = 3'b100,
  parameter bit [2:0] BG_RECORD = 3'b010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       round_won,
  input  logic       game_over,
  output logic [3:0] level_10,
  output logic [3:0] level_01,
  output logic [3:0] max_score_10,
  output logic [3:0] max_score_01,
  output logic [2:0] bg,
  output logic       new_record,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;

  localparam logic [3:0] MAX_10 = 4'(MAX_LEVEL / 10);
  localparam logic [3:0] MAX_01 = 4'(MAX_LEVEL % 10);

  state_t     state_q;
  logic [3:0] lvl_10_q;
  logic [3:0] lvl_01_q;
  logic [3:0] max_10_q;
  logic [3:0] max_01_q;
  logic [2:0] bg_q;
  logic       rec_q;

  logic at_max;
  logic beats_max;

  assign at_max    = (lvl_10_q == MAX_10) && (lvl_01_q == MAX_01);
  // BCD digit pairs order the same way as the binary concatenation
  assign beats_max = {lvl_10_q, lvl_01_q} > {max_10_q, max_01_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lvl_10_q <= 4'd0;
      lvl_01_q <= 4'd0;
      max_10_q <= 4'd0;
      max_01_q <= 4'd0;
      bg_q     <= BG_IDLE;
      rec_q    <= 1'b0;
    end else if (new_game) begin
      state_q  <= S_PLAY;
      lvl_10_q <= 4'd0;
      lvl_01_q <= 4'd0;
      bg_q     <= BG_PLAY;
      rec_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          bg_q <= BG_IDLE;
        end
        S_PLAY: begin
          if (game_over) begin
            state_q <= S_OVER;
            rec_q   <= beats_max;
            bg_q    <= beats_max ? BG_RECORD : BG_OVER;
            if (beats_max) begin
              max_10_q <= lvl_10_q;
              max_01_q <= lvl_01_q;
            end
          end else if (round_won && !at_max) begin
            if (lvl_01_q == 4'd9) begin
              lvl_01_q <= 4'd0;
              lvl_10_q <= lvl_10_q + 4'd1;
            end else begin
              lvl_01_q <= lvl_01_q + 4'd1;
            end
          end
        end
        S_OVER: begin
          bg_q <= rec_q ? BG_RECORD : BG_OVER;
        end
        default: begin
          state_q <= S_IDLE;
          bg_q    <= BG_IDLE;
          rec_q   <= 1'b0;
        end
      endcase
    end
  end

  assign state        = state_q;
  assign level_10     = lvl_10_q;
  assign level_01     = lvl_01_q;
  assign max_score_10 = max_10_q;
  assign max_score_01 = max_01_q;
  assign bg           = bg_q;
  assign new_record   = rec_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus random pulses,
// every cycle compared with an integer reference model.
module tb_score_keeper;

  logic       clk;
  logic       rst_n;
  logic       new_game;
  logic       round_won;
  logic       game_over;
  logic [3:0] level_10;
  logic [3:0] level_01;
  logic [3:0] max_score_10;
  logic [3:0] max_score_01;
  logic [2:0] bg;
  logic       new_record;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  int m_lvl;
  int m_max;
  int m_st;
  bit m_rec;

  score_keeper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_game     (new_game),
    .round_won    (round_won),
    .game_over    (game_over),
    .level_10     (level_10),
    .level_01     (level_01),
    .max_score_10 (max_score_10),
    .max_score_01 (max_score_01),
    .bg           (bg),
    .new_record   (new_record),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Game rules in plain integer form: level 0..99, states 0/1/2.
  task automatic model(input bit r, input bit ng,
                       input bit rw, input bit go);
    if (!r) begin
      m_st = 0; m_lvl = 0; m_max = 0; m_rec = 0;
    end else if (ng) begin
      m_st = 1; m_lvl = 0; m_rec = 0;
    end else if (m_st == 1) begin
      if (go) begin
        m_st = 2;
        if (m_lvl > m_max) begin
          m_max = m_lvl;
          m_rec = 1;
        end
      end else if (rw && m_lvl < 99) begin
        m_lvl++;
      end
    end
  endtask

  function automatic logic [2:0] exp_bg();
    if (m_st == 0) return 3'b001;
    if (m_st == 1) return 3'b000;
    return m_rec ? 3'b010 : 3'b100;
  endfunction

  task automatic check_all();
    chk("state", {6'd0, state}, 8'(m_st));
    chk("level_10", {4'd0, level_10}, 8'(m_lvl / 10));
    chk("level_01", {4'd0, level_01}, 8'(m_lvl % 10));
    chk("max_10", {4'd0, max_score_10}, 8'(m_max / 10));
    chk("max_01", {4'd0, max_score_01}, 8'(m_max % 10));
    chk("new_record", {7'd0, new_record}, {7'd0, m_rec});
    chk("bg", {5'd0, bg}, {5'd0, exp_bg()});
  endtask

  task automatic step(input bit r, input bit ng,
                      input bit rw, input bit go);
    @(negedge clk);
    rst_n     = r;
    new_game  = ng;
    round_won = rw;
    game_over = go;
    model(r, ng, rw, go);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    new_game  = 1'b0;
    round_won = 1'b0;
    game_over = 1'b0;
    check_all();
  endtask

  task automatic rounds(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0; new_game = 1'b0;
    round_won = 1'b0; game_over = 1'b0;
    m_st = 0; m_lvl = 0; m_max = 0; m_rec = 0;

    // reset wins over simultaneous pulses
    step(0, 1, 1, 1);
    step(0, 0, 0, 0);
    chk("rst_bg", {5'd0, bg}, 8'h01);
    chk("rst_state", {6'd0, state}, 8'h00);

    // pulses ignored in IDLE, then first new_game honoured
    step(1, 0, 1, 0);
    step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    rounds(12);
    chk("l12_digits", {level_10, level_01}, 8'h12);
    chk("l12_state", {6'd0, state}, 8'h01);

    step(1, 0, 0, 1);
    chk("rec_max", {max_score_10, max_score_01}, 8'h12);
    chk("rec_bg", {5'd0, bg}, 8'h02);
    step(1, 0, 1, 1);

    step(1, 1, 0, 0);
    rounds(5);
    step(1, 0, 0, 1);
    chk("lower_bg", {5'd0, bg}, 8'h04);
    chk("lower_max", {max_score_10, max_score_01}, 8'h12);

    // tie, then game_over with same-cycle round_won at 12
    step(1, 1, 0, 0);
    rounds(12);
    step(1, 0, 1, 1);
    chk("tie_rec", {7'd0, new_record}, 8'h00);
    chk("tie_lvl", {level_10, level_01}, 8'h12);
    chk("tie_state", {6'd0, state}, 8'h02);

    // BCD carry and saturation
    step(1, 1, 0, 0);
    rounds(9);
    chk("l09", {level_10, level_01}, 8'h09);
    rounds(1);
    chk("l10", {level_10, level_01}, 8'h10);
    rounds(89);
    chk("l99", {level_10, level_01}, 8'h99);
    rounds(2);
    chk("l99_hold", {level_10, level_01}, 8'h99);
    step(1, 0, 0, 1);
    chk("max99", {max_score_10, max_score_01}, 8'h99);

    // new_game beats game_over
    step(1, 1, 0, 0);
    rounds(3);
    step(1, 1, 0, 1);
    chk("ng_go_lvl", {level_10, level_01}, 8'h00);
    chk("ng_go_st", {6'd0, state}, 8'h01);

    // reset mid-play clears max
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    rounds(12);
    step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    rounds(7);
    step(0, 0, 1, 0);
    chk("midrst_all",
        {max_score_10, max_score_01}, 8'h00);
    chk("midrst_bg", {5'd0, bg}, 8'h01);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
